// File: rtl/bru_pipeline.sv
// bru_pipeline
// Branch Resolution Unit execution pipeline, downstream of the BRU issue queue.
// Two stages: OC (operand collect) and OUT (writeback / branch notification).
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   issue_*                        one issued BRU op per cycle (op, PC, imm,
//                                  speculated next PC, operand source flags,
//                                  destination PR, ROB tag)
//   pipeline_ready                 OC can take an op this cycle (combinational)
//   A/B_reg_read_ack/_data         PRF read responses, any OC cycle
//   WB_bus_data_by_bank            forward data, sampled in the first OC cycle
//   WB_valid/ready/data/PR/ROB     register writeback, valid/ready handshake
//   branch_notif_*                 one-cycle resolution pulse with next PC and
//                                  mispredict flag
//
// Handshake: WB_valid is raised with stable WB_data/WB_PR/WB_ROB_index and
// held until the cycle WB_ready is also high; that cycle completes the
// transfer and OUT may reload in the same cycle.
module bru_pipeline #(
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_ROB_ENTRIES    = 7,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic                                 issue_valid,
    input  logic [3:0]                           issue_op,
    input  logic [31:0]                          issue_PC,
    input  logic [31:0]                          issue_speculated_next_PC,
    input  logic [31:0]                          issue_imm,
    input  logic                                 issue_A_unneeded,
    input  logic                                 issue_A_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_A_bank,
    input  logic                                 issue_B_unneeded,
    input  logic                                 issue_B_forward,
    input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_B_bank,
    input  logic [LOG_PR_COUNT-1:0]              issue_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]           issue_ROB_index,
    output logic                                 pipeline_ready,
    input  logic                                 A_reg_read_ack,
    input  logic [31:0]                          A_reg_read_data,
    input  logic                                 B_reg_read_ack,
    input  logic [31:0]                          B_reg_read_data,
    input  logic [PRF_BANK_COUNT-1:0][31:0]      WB_bus_data_by_bank,
    output logic                                 WB_valid,
    input  logic                                 WB_ready,
    output logic [31:0]                          WB_data,
    output logic [LOG_PR_COUNT-1:0]              WB_PR,
    output logic [LOG_ROB_ENTRIES-1:0]           WB_ROB_index,
    output logic                                 branch_notif_valid,
    output logic [LOG_ROB_ENTRIES-1:0]           branch_notif_ROB_index,
    output logic                                 branch_notif_mispredict,
    output logic [31:0]                          branch_notif_next_PC
);

    // OC stage
    logic                          oc_valid_q, oc_first_q;
    logic [3:0]                    oc_op_q;
    logic [31:0]                   oc_pc_q, oc_spec_q, oc_imm_q;
    logic [LOG_PR_COUNT-1:0]       oc_pr_q;
    logic [LOG_ROB_ENTRIES-1:0]    oc_rob_q;
    logic                          oc_a_fwd_q, oc_b_fwd_q;
    logic [LOG_PRF_BANK_COUNT-1:0] oc_a_bank_q, oc_b_bank_q;
    logic                          a_done_q, b_done_q, a_done_d, b_done_d;
    logic [31:0]                   a_data_q, b_data_q, a_data_d, b_data_d;

    // OUT stage
    logic                          out_valid_q;
    logic [31:0]                   out_data_q;
    logic [LOG_PR_COUNT-1:0]       out_pr_q;
    logic [LOG_ROB_ENTRIES-1:0]    out_rob_q;
    logic                          notif_valid_q, notif_misp_q;
    logic [LOG_ROB_ENTRIES-1:0]    notif_rob_q;
    logic [31:0]                   notif_npc_q;

    logic a_fwd_now, b_fwd_now, a_ack_ok, b_ack_ok;
    logic oc_advance, oc_load;

    // Forward data only exists in the first OC cycle. PRF acks count only for
    // operands that are actually waiting on the PRF, so stray acks for
    // unneeded/forwarded operands (including one coinciding with the forward
    // capture) are ignored.
    assign a_fwd_now = oc_first_q & oc_a_fwd_q & ~a_done_q;
    assign b_fwd_now = oc_first_q & oc_b_fwd_q & ~b_done_q;
    assign a_ack_ok  = A_reg_read_ack & ~oc_a_fwd_q & ~a_done_q;
    assign b_ack_ok  = B_reg_read_ack & ~oc_b_fwd_q & ~b_done_q;

    assign a_done_d = a_done_q | a_fwd_now | a_ack_ok;
    assign b_done_d = b_done_q | b_fwd_now | b_ack_ok;
    assign a_data_d = a_fwd_now ? WB_bus_data_by_bank[oc_a_bank_q]
                    : a_ack_ok  ? A_reg_read_data : a_data_q;
    assign b_data_d = b_fwd_now ? WB_bus_data_by_bank[oc_b_bank_q]
                    : b_ack_ok  ? B_reg_read_data : b_data_q;

    // OUT only blocks when it holds a write that has not been accepted;
    // non-writing ops leave OUT immediately.
    assign oc_advance     = oc_valid_q & a_done_d & b_done_d & (~out_valid_q | WB_ready);
    assign pipeline_ready = ~oc_valid_q | oc_advance;
    assign oc_load        = issue_valid & pipeline_ready;

    // Result computation on the operands as seen this cycle
    logic        res_writes, res_notif, taken;
    logic [31:0] res_data, res_npc, pc_plus4, pc_plus2, pc_imm, a_imm;

    always_comb begin
        pc_plus4   = oc_pc_q + 32'd4;
        pc_plus2   = oc_pc_q + 32'd2;
        pc_imm     = oc_pc_q + oc_imm_q;
        a_imm      = (a_data_d + oc_imm_q) & 32'hFFFF_FFFE;
        res_writes = 1'b0;
        res_notif  = 1'b1;
        res_data   = 32'd0;
        res_npc    = pc_plus4;
        taken      = 1'b0;
        case (oc_op_q)
            4'h0: begin res_writes = 1'b1; res_data = pc_plus4; res_npc = a_imm;  end
            4'h1: begin res_writes = 1'b1; res_data = pc_plus2; res_npc = a_imm;  end
            4'h2: begin res_writes = 1'b1; res_data = pc_plus4; res_npc = pc_imm; end
            4'h3: begin res_writes = 1'b1; res_data = pc_plus2; res_npc = pc_imm; end
            4'h4: res_npc = pc_imm;
            4'h5: res_npc = a_imm;
            4'h6: begin res_writes = 1'b1; res_notif = 1'b0; res_data = oc_imm_q; end
            4'h7: begin res_writes = 1'b1; res_notif = 1'b0; res_data = pc_imm;   end
            default: begin
                case (oc_op_q)
                    4'h8:    taken = (a_data_d == b_data_d);
                    4'h9:    taken = (a_data_d != b_data_d);
                    4'hA:    taken = (a_data_d == 32'd0);
                    4'hB:    taken = (a_data_d != 32'd0);
                    4'hC:    taken = ($signed(a_data_d) <  $signed(b_data_d));
                    4'hD:    taken = ($signed(a_data_d) >= $signed(b_data_d));
                    4'hE:    taken = (a_data_d <  b_data_d);
                    default: taken = (a_data_d >= b_data_d);
                endcase
                // Compressed branches fall through by 2
                if (taken)
                    res_npc = pc_imm;
                else if (oc_op_q == 4'hA || oc_op_q == 4'hB)
                    res_npc = pc_plus2;
                else
                    res_npc = pc_plus4;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            oc_valid_q  <= 1'b0;
            oc_first_q  <= 1'b0;
            oc_op_q     <= '0;
            oc_pc_q     <= '0;
            oc_spec_q   <= '0;
            oc_imm_q    <= '0;
            oc_pr_q     <= '0;
            oc_rob_q    <= '0;
            oc_a_fwd_q  <= 1'b0;
            oc_b_fwd_q  <= 1'b0;
            oc_a_bank_q <= '0;
            oc_b_bank_q <= '0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_data_q    <= '0;
            b_data_q    <= '0;
        end else if (oc_load) begin
            oc_valid_q  <= 1'b1;
            oc_first_q  <= 1'b1;
            oc_op_q     <= issue_op;
            oc_pc_q     <= issue_PC;
            oc_spec_q   <= issue_speculated_next_PC;
            oc_imm_q    <= issue_imm;
            oc_pr_q     <= issue_dest_PR;
            oc_rob_q    <= issue_ROB_index;
            oc_a_fwd_q  <= issue_A_forward & ~issue_A_unneeded;
            oc_b_fwd_q  <= issue_B_forward & ~issue_B_unneeded;
            oc_a_bank_q <= issue_A_bank;
            oc_b_bank_q <= issue_B_bank;
            a_done_q    <= issue_A_unneeded;
            b_done_q    <= issue_B_unneeded;
            a_data_q    <= '0;
            b_data_q    <= '0;
        end else begin
            if (oc_advance)
                oc_valid_q <= 1'b0;
            oc_first_q <= 1'b0;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_pr_q      <= '0;
            out_rob_q     <= '0;
            notif_valid_q <= 1'b0;
            notif_misp_q  <= 1'b0;
            notif_rob_q   <= '0;
            notif_npc_q   <= '0;
        end else if (oc_advance) begin
            out_valid_q   <= res_writes;
            out_data_q    <= res_data;
            out_pr_q      <= oc_pr_q;
            out_rob_q     <= oc_rob_q;
            notif_valid_q <= res_notif;
            notif_misp_q  <= (res_npc != oc_spec_q);
            notif_rob_q   <= oc_rob_q;
            notif_npc_q   <= res_npc;
        end else begin
            if (WB_ready)
                out_valid_q <= 1'b0;
            notif_valid_q <= 1'b0;
        end
    end

    assign WB_valid                = out_valid_q;
    assign WB_data                 = out_data_q;
    assign WB_PR                   = out_pr_q;
    assign WB_ROB_index            = out_rob_q;
    assign branch_notif_valid      = notif_valid_q;
    assign branch_notif_ROB_index  = notif_rob_q;
    assign branch_notif_mispredict = notif_misp_q;
    assign branch_notif_next_PC    = notif_npc_q;

endmodule

// File: tb/tb_bru_pipeline.sv
module tb_bru_pipeline;
  localparam int PRW = 7;
  localparam int RBW = 7;
  localparam int NB  = 4;
  localparam int BW  = 2;
  localparam int N_BURST = 24;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic            issue_valid;
  logic [3:0]      issue_op;
  logic [31:0]     issue_PC, issue_speculated_next_PC, issue_imm;
  logic            issue_A_unneeded, issue_A_forward, issue_B_unneeded, issue_B_forward;
  logic [BW-1:0]   issue_A_bank, issue_B_bank;
  logic [PRW-1:0]  issue_dest_PR;
  logic [RBW-1:0]  issue_ROB_index;
  logic            pipeline_ready;
  logic            A_reg_read_ack, B_reg_read_ack;
  logic [31:0]     A_reg_read_data, B_reg_read_data;
  logic [NB-1:0][31:0] WB_bus_data_by_bank;
  logic            WB_valid, WB_ready;
  logic [31:0]     WB_data;
  logic [PRW-1:0]  WB_PR;
  logic [RBW-1:0]  WB_ROB_index;
  logic            branch_notif_valid, branch_notif_mispredict;
  logic [RBW-1:0]  branch_notif_ROB_index;
  logic [31:0]     branch_notif_next_PC;

  bru_pipeline dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_PC(issue_PC),
    .issue_speculated_next_PC(issue_speculated_next_PC), .issue_imm(issue_imm),
    .issue_A_unneeded(issue_A_unneeded), .issue_A_forward(issue_A_forward), .issue_A_bank(issue_A_bank),
    .issue_B_unneeded(issue_B_unneeded), .issue_B_forward(issue_B_forward), .issue_B_bank(issue_B_bank),
    .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index),
    .pipeline_ready(pipeline_ready),
    .A_reg_read_ack(A_reg_read_ack), .A_reg_read_data(A_reg_read_data),
    .B_reg_read_ack(B_reg_read_ack), .B_reg_read_data(B_reg_read_data),
    .WB_bus_data_by_bank(WB_bus_data_by_bank),
    .WB_valid(WB_valid), .WB_ready(WB_ready), .WB_data(WB_data), .WB_PR(WB_PR),
    .WB_ROB_index(WB_ROB_index),
    .branch_notif_valid(branch_notif_valid), .branch_notif_ROB_index(branch_notif_ROB_index),
    .branch_notif_mispredict(branch_notif_mispredict), .branch_notif_next_PC(branch_notif_next_PC)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [PRW+RBW+31:0] exp_wb_q[$];   // {PR, ROB, data}
  logic [RBW+32:0]     exp_nt_q[$];   // {ROB, mispredict, next_PC}
  logic [PRW+RBW+31:0] mon_wb;
  logic [RBW+32:0]     mon_nt;
  logic [RBW-1:0]      rob_ctr = '0;

  logic [3:0]  b_op[N_BURST];
  logic [31:0] b_a[N_BURST], b_b[N_BURST];
  logic        b_fw[N_BURST];
  logic [1:0]  b_bank[N_BURST];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one op
  function automatic void model(input logic [3:0] op, input logic [31:0] pc, imm, a, b,
                                output logic wr, output logic [31:0] wd,
                                output logic nt, output logic [31:0] npc);
    logic tk;
    tk = 1'b0; wr = 1'b0; wd = 32'd0; nt = 1'b1; npc = pc + 32'd4;
    case (op)
      4'h0: begin wr = 1'b1; wd = pc + 32'd4; npc = (a + imm) & 32'hFFFF_FFFE; end
      4'h1: begin wr = 1'b1; wd = pc + 32'd2; npc = (a + imm) & 32'hFFFF_FFFE; end
      4'h2: begin wr = 1'b1; wd = pc + 32'd4; npc = pc + imm; end
      4'h3: begin wr = 1'b1; wd = pc + 32'd2; npc = pc + imm; end
      4'h4: npc = pc + imm;
      4'h5: npc = (a + imm) & 32'hFFFF_FFFE;
      4'h6: begin wr = 1'b1; nt = 1'b0; wd = imm; end
      4'h7: begin wr = 1'b1; nt = 1'b0; wd = pc + imm; end
      default: begin
        case (op)
          4'h8: tk = (a == b);
          4'h9: tk = (a != b);
          4'hA: tk = (a == 0);
          4'hB: tk = (a != 0);
          4'hC: tk = $signed(a) < $signed(b);
          4'hD: tk = $signed(a) >= $signed(b);
          4'hE: tk = a < b;
          default: tk = a >= b;
        endcase
        npc = tk ? pc + imm : ((op == 4'hA || op == 4'hB) ? pc + 32'd2 : pc + 32'd4);
      end
    endcase
  endfunction

  task automatic push_exp(input logic [3:0] op, input logic [31:0] pc, imm, a, b, spec,
                          input logic [PRW-1:0] pr, input logic [RBW-1:0] rob);
    logic wr, nt;
    logic [31:0] wd, npc;
    model(op, pc, imm, a, b, wr, wd, nt, npc);
    if (wr) exp_wb_q.push_back({pr, rob, wd});
    if (nt) exp_nt_q.push_back({rob, npc != spec, npc});
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [31:0] pc, imm, spec,
                             input logic a_un, a_fw, input logic [1:0] a_bk,
                             input logic b_un, b_fw, input logic [1:0] b_bk,
                             input logic [PRW-1:0] pr);
    issue_valid = 1'b1; issue_op = op; issue_PC = pc; issue_imm = imm;
    issue_speculated_next_PC = spec;
    issue_A_unneeded = a_un; issue_A_forward = a_fw; issue_A_bank = a_bk;
    issue_B_unneeded = b_un; issue_B_forward = b_fw; issue_B_bank = b_bk;
    issue_dest_PR = pr; issue_ROB_index = rob_ctr;
  endtask

  task automatic clear_inputs;
    issue_valid = 1'b0;
    A_reg_read_ack = 1'b0; B_reg_read_ack = 1'b0;
    A_reg_read_data = 32'd0; B_reg_read_data = 32'd0;
    WB_bus_data_by_bank = '0;
  endtask

  // Scoreboard: compare every accepted writeback and every notification pulse
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (WB_valid && WB_ready) begin
        check_eq("wb_expected", exp_wb_q.size() != 0, 1'b1);
        if (exp_wb_q.size() != 0) begin
          mon_wb = exp_wb_q.pop_front();
          check_eq("wb_fields", {WB_PR, WB_ROB_index, WB_data}, mon_wb);
        end
      end
      if (branch_notif_valid) begin
        check_eq("notif_expected", exp_nt_q.size() != 0, 1'b1);
        if (exp_nt_q.size() != 0) begin
          mon_nt = exp_nt_q.pop_front();
          check_eq("notif_fields",
                   {branch_notif_ROB_index, branch_notif_mispredict, branch_notif_next_PC}, mon_nt);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    issue_op = '0; issue_PC = '0; issue_imm = '0; issue_speculated_next_PC = '0;
    issue_A_unneeded = 1'b0; issue_A_forward = 1'b0; issue_A_bank = '0;
    issue_B_unneeded = 1'b0; issue_B_forward = 1'b0; issue_B_bank = '0;
    issue_dest_PR = '0; issue_ROB_index = '0;
    WB_ready = 1'b1;
    nRST = 1'b0;
    #3;
    check_eq("rst_ready", pipeline_ready, 1'b1);
    check_eq("rst_wb_valid", WB_valid, 1'b0);
    check_eq("rst_notif", branch_notif_valid, 1'b0);
    check_eq("rst_fields", {WB_data, WB_PR, branch_notif_next_PC, branch_notif_mispredict}, '0);
    tick(); tick();
    nRST = 1'b1;
    tick();

    // BEQ, both operands from PRF one cycle after issue
    drive_issue(4'h8, 32'h100, 32'h20, 32'h104, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 7'd0);
    push_exp(4'h8, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 7'd0, rob_ctr); rob_ctr++;
    tick();
    clear_inputs();
    A_reg_read_ack = 1'b1; A_reg_read_data = 32'd5;
    B_reg_read_ack = 1'b1; B_reg_read_data = 32'd5;
    tick();
    clear_inputs();
    check_eq("beq_notif_t2", branch_notif_valid, 1'b1);
    check_eq("beq_no_wb", WB_valid, 1'b0);
    tick(); tick();

    // JAL, no operands
    drive_issue(4'h2, 32'h200, 32'h40, 32'h240, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 7'd9);
    push_exp(4'h2, 32'h200, 32'h40, 32'd0, 32'd0, 32'h240, 7'd9, rob_ctr); rob_ctr++;
    tick();
    clear_inputs();
    tick();
    check_eq("jal_wb_t2", WB_valid, 1'b1);
    check_eq("jal_notif_t2", branch_notif_valid, 1'b1);
    tick(); tick();

    // C.JALR, A forwarded from bank 2; a stray PRF ack must be ignored
    drive_issue(4'h1, 32'h300, 32'h0, 32'h1004, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 7'd5);
    push_exp(4'h1, 32'h300, 32'h0, 32'h1001, 32'd0, 32'h1004, 7'd5, rob_ctr); rob_ctr++;
    tick();
    clear_inputs();
    WB_bus_data_by_bank[2] = 32'h1001;
    A_reg_read_ack = 1'b1; A_reg_read_data = 32'hDEAD;
    tick();
    clear_inputs();
    tick(); tick();

    // BNE with A ack delayed 3 cycles; LUI held on issue meanwhile
    drive_issue(4'h9, 32'h400, 32'h10, 32'h404, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 7'd0);
    push_exp(4'h9, 32'h400, 32'h10, 32'd7, 32'd8, 32'h404, 7'd0, rob_ctr); rob_ctr++;
    tick();
    clear_inputs();
    drive_issue(4'h6, 32'h480, 32'h1234_5000, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 7'd3);
    B_reg_read_ack = 1'b1; B_reg_read_data = 32'd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("dly_ready_%0d", k), pipeline_ready, 1'b0);
      tick();
      B_reg_read_ack = 1'b0; B_reg_read_data = 32'hBAD;
    end
    A_reg_read_ack = 1'b1; A_reg_read_data = 32'd7;
    #1;
    check_eq("dly_ready_adv", pipeline_ready, 1'b1);
    push_exp(4'h6, 32'h480, 32'h1234_5000, 32'd0, 32'd0, 32'h0, 7'd3, rob_ctr); rob_ctr++;
    tick();
    clear_inputs();
    tick(); tick(); tick();

    // WB stall with JAL in OUT and a second JAL waiting in OC
    WB_ready = 1'b0;
    drive_issue(4'h2, 32'h500, 32'h100, 32'h600, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 7'd10);
    push_exp(4'h2, 32'h500, 32'h100, 32'd0, 32'd0, 32'h600, 7'd10, rob_ctr); rob_ctr++;
    tick();
    drive_issue(4'h3, 32'h700, 32'h8, 32'h700, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 7'd11);
    #1;
    check_eq("stall_ready_pre", pipeline_ready, 1'b1);
    push_exp(4'h3, 32'h700, 32'h8, 32'd0, 32'd0, 32'h700, 7'd11, rob_ctr); rob_ctr++;
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("stall_wb_%0d", k), {WB_valid, WB_PR, WB_data}, {1'b1, 7'd10, 32'h504});
      check_eq($sformatf("stall_ready_%0d", k), pipeline_ready, 1'b0);
      tick();
    end
    WB_ready = 1'b1;
    tick(); tick(); tick();

    // BLTU not taken, BLT taken with identical operands
    drive_issue(4'hE, 32'h600, 32'h80, 32'h604, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 7'd0);
    push_exp(4'hE, 32'h600, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h604, 7'd0, rob_ctr); rob_ctr++;
    tick();
    drive_issue(4'hC, 32'h600, 32'h80, 32'h604, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 7'd0);
    push_exp(4'hC, 32'h600, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h604, 7'd0, rob_ctr); rob_ctr++;
    A_reg_read_ack = 1'b1; A_reg_read_data = 32'hFFFF_FFFF;
    B_reg_read_ack = 1'b1; B_reg_read_data = 32'd1;
    tick();
    issue_valid = 1'b0;
    tick();
    clear_inputs();
    tick(); tick(); tick();

    // Random back-to-back burst: operands delivered in each op's first OC cycle
    for (int i = 0; i < N_BURST; i++) begin
      b_op[i]   = 4'($urandom_range(0, 15));
      b_a[i]    = $urandom();
      b_b[i]    = ($urandom_range(0, 1) == 1) ? b_a[i] : $urandom();
      b_fw[i]   = 1'($urandom_range(0, 1));
      b_bank[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i <= N_BURST; i++) begin
      clear_inputs();
      if (i < N_BURST) begin
        logic [31:0] pc, imm, spec;
        pc   = $urandom() & 32'hFFFF_FFFE;
        imm  = $urandom() & 32'hFFFF_FFFE;
        spec = ($urandom_range(0, 1) == 1) ? pc + imm : pc + 32'd4;
        drive_issue(b_op[i], pc, imm, spec, 1'b0, b_fw[i], b_bank[i], 1'b0, 1'b0, 2'd0,
                    7'($urandom_range(0, 127)));
        push_exp(b_op[i], pc, imm, b_a[i], b_b[i], spec, issue_dest_PR, rob_ctr); rob_ctr++;
      end
      if (i > 0) begin
        if (b_fw[i-1]) begin
          WB_bus_data_by_bank[b_bank[i-1]] = b_a[i-1];
          A_reg_read_ack = 1'b1; A_reg_read_data = ~b_a[i-1];
        end else begin
          A_reg_read_ack = 1'b1; A_reg_read_data = b_a[i-1];
        end
        B_reg_read_ack = 1'b1; B_reg_read_data = b_b[i-1];
      end
      #1;
      check_eq($sformatf("burst_ready_%0d", i), pipeline_ready, 1'b1);
      tick();
    end
    clear_inputs();
    tick(); tick(); tick();

    // Reset in the middle of a WB stall
    WB_ready = 1'b0;
    drive_issue(4'h2, 32'h800, 32'h10, 32'h810, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 7'd12);
    push_exp(4'h2, 32'h800, 32'h10, 32'd0, 32'd0, 32'h810, 7'd12, rob_ctr); rob_ctr++;
    tick();
    drive_issue(4'h0, 32'h900, 32'h10, 32'h910, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 7'd13);
    tick();
    clear_inputs();
    tick();
    nRST = 1'b0;
    #1;
    check_eq("mid_rst_ready", pipeline_ready, 1'b1);
    check_eq("mid_rst_valids", {WB_valid, branch_notif_valid}, 2'b00);
    check_eq("mid_rst_fields", {WB_data, WB_PR, WB_ROB_index, branch_notif_next_PC}, '0);
    exp_wb_q.delete();
    exp_nt_q.delete();
    WB_ready = 1'b1;
    tick(); tick();
    nRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("post_rst_quiet_%0d", k), {WB_valid, branch_notif_valid}, 2'b00);
    end

    check_eq("wb_q_drained", exp_wb_q.size(), 0);
    check_eq("nt_q_drained", exp_nt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bru_pipeline.md
Name: bru_pipeline

Overview:
- Branch Resolution Unit execution pipeline, directly downstream of the BRU issue queue.
- Accepts one issued BRU op per cycle and collects operands from PRF read responses or WB-bus forward data.
- Computes link/result values and the resolved next PC, flags mispredicts.
- Sends register writeback (ready/valid) and a single-pulse branch notification to the ROB/fetch restart logic.

Parameters:
LOG_PR_COUNT, 7, physical register index width
LOG_ROB_ENTRIES, 7, ROB index width
PRF_BANK_COUNT, 4, PRF banks / WB buses
LOG_PRF_BANK_COUNT, 2, bank select width

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
issue_valid  in  1  op issued this cycle
issue_op  in  4  op encoding (see Behaviour)
issue_PC, issue_speculated_next_PC, issue_imm  in  32 each  op fields
issue_A_unneeded, issue_A_forward  in  1 each  A operand source flags
issue_A_bank  in  LOG_PRF_BANK_COUNT  A forward bank
issue_B_unneeded, issue_B_forward, issue_B_bank  in  1/1/LOG_PRF_BANK_COUNT  B equivalents
issue_dest_PR  in  LOG_PR_COUNT  destination PR
issue_ROB_index  in  LOG_ROB_ENTRIES  ROB tag
pipeline_ready  out  1  may accept issue this cycle
A_reg_read_ack, B_reg_read_ack  in  1 each  PRF read data valid
A_reg_read_data, B_reg_read_data  in  32 each  PRF read data
WB_bus_data_by_bank  in  PRF_BANK_COUNT x 32  forward data, one cycle after WB_bus_valid
WB_valid  out  1  register write valid
WB_ready  in  1  writeback accepted
WB_data  out  32  write value
WB_PR  out  LOG_PR_COUNT  write PR
WB_ROB_index  out  LOG_ROB_ENTRIES  ROB tag
branch_notif_valid  out  1  one-cycle resolution pulse
branch_notif_ROB_index  out  LOG_ROB_ENTRIES  ROB tag
branch_notif_mispredict  out  1  resolved next PC != speculated
branch_notif_next_PC  out  32  resolved next PC

Behaviour:
- Stages: OC (operand collect) register, then OUT register. Issue at cycle t; earliest WB_valid/branch_notif_valid at t+2.
- pipeline_ready = ~OC_valid | OC_advance; combinational; reset value 1.
- OC loads when issue_valid & pipeline_ready. Each operand is done if unneeded, or forward (capture WB_bus_data_by_bank[bank] in the first OC cycle only), or PRF ack (capture data in any ack cycle).
- Acks arriving for an unneeded/forwarded operand are ignored. Ack in the same cycle as the forward capture is ignored.
- OC_advance = A_done & B_done & (~OUT_valid | WB_ready | ~OUT_writes). While stalled, captured operands are held.
- Op encoding:
  - 0 JALR, 1 C.JALR, 2 JAL, 3 C.JAL, 4 C.J, 5 C.JR, 6 LUI, 7 AUIPC
  - 8 BEQ, 9 BNE, A C.BEQZ, B C.BNEZ, C BLT, D BGE, E BLTU, F BGEU
- Results and writes:
  - Ops 0-3 write link = PC+4, or PC+2 for C. forms.
  - Op 6 writes imm. Op 7 writes PC+imm.
  - Ops 4, 5 and 8-F do not write (WB_valid stays 0).
- Next PC:
  - Ops 0 and 5: (A+imm) & ~1.
  - Ops 2-4: PC+imm.
  - Branches: PC+imm if taken, else PC+4 (PC+2 for A, B).
  - C.BEQZ/C.BNEZ compare A against 0. BLT/BGE are signed; BLTU/BGEU are unsigned.
  - 32-bit adds wrap modulo 2^32.
- branch_notif fires for all ops except 6 and 7.
  - It pulses exactly one cycle: the cycle after OUT loads, independent of WB_ready.
  - mispredict = (next_PC != speculated_next_PC).
- WB_valid holds with stable fields until WB_ready. OUT loads a new op in the handshake cycle (back-to-back throughput 1/cycle).
- Reset (async, any cycle): OC/OUT invalid, all outputs 0 except pipeline_ready = 1. In-flight ops are dropped.

Test Plan:
- BEQ: PC=0x100, imm=0x20, A=B=5 both via PRF ack next cycle, speculated=0x104 -> t+2 branch_notif_valid=1, next_PC=0x120, mispredict=1, WB_valid=0.
- JAL: PC=0x200, imm=0x40, spec=0x240, dest_PR=9 -> WB_valid=1, WB_data=0x204, WB_PR=9, notif mispredict=0, next_PC=0x240.
- C.JALR: A forwarded from bank 2 with data 0x1001, imm=0, PC=0x300 -> next_PC=0x1000, WB_data=0x302.
- PRF ack for A delayed 3 cycles -> pipeline_ready=0 during wait, second issue accepted only once OC advances, results in order.
- WB_ready low 4 cycles with JAL in OUT -> WB fields stable, notif pulses once, OC stalls.
- BLTU: A=0xFFFFFFFF, B=1 -> not taken, next_PC=PC+4. BLT with same operands -> taken.
- Reset asserted mid-stall -> all outputs 0 and pipeline_ready=1 immediately, no notif after release.
